// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register arbiter: FSM state encoding,
// index-width sizing and one-hot to index conversion.
package reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/dff_en.sv
// WIDTH-bit storage register with synchronous active-low reset to RESET_VAL
// and a load enable.
module dff_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter sharing one register between N requesters.
// Optional grant locking is compiled in with `define REG_ARB_LOCK_EN.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int               N         = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               MAX_LOCK  = 8,
  localparam int              IDX_W     = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               wr_valid,
  output logic [IDX_W-1:0]   wr_src
);

  arb_state_e       state, state_n;
  logic [N-1:0]     gnt_n;
  logic [IDX_W-1:0] ptr, ptr_n, g, base, win;
  logic             wr_en, hold, found;
  int               idx;

  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef REG_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [LCW-1:0] lock_cnt, lock_cnt_n, cnt_inc;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    g       = IDX_W'(onehot_to_idx(32'(gnt)));
    wr_en   = (state != IDLE) && req[g];
    base    = ptr;
    hold    = 1'b0;
`ifdef REG_ARB_LOCK_EN
    cnt_inc = lock_cnt + 1'b1;
`endif
    case (state)
      GRANT: begin
        if (wr_en) base = inc(g);
`ifdef REG_ARB_LOCK_EN
        // The write that takes the lock counts toward MAX_LOCK.
        if (wr_en && lock[g] && MAX_LOCK > 1) hold = 1'b1;
`endif
      end
`ifdef REG_ARB_LOCK_EN
      LOCKED: begin
        base = inc(g);
        if (wr_en && lock[g] && cnt_inc < LCW'(MAX_LOCK)) hold = 1'b1;
      end
`endif
      default: ;
    endcase

    // Round-robin pick starting from the post-update pointer.
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end

    state_n = IDLE;
    gnt_n   = '0;
    ptr_n   = base;
`ifdef REG_ARB_LOCK_EN
    lock_cnt_n = '0;
`endif
    if (hold) begin
      state_n = LOCKED;
      gnt_n   = gnt;
      ptr_n   = ptr;
`ifdef REG_ARB_LOCK_EN
      lock_cnt_n = (state == GRANT) ? LCW'(1) : cnt_inc;
`endif
    end else if (found) begin
      state_n    = GRANT;
      gnt_n[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      wr_valid <= 1'b0;
      wr_src   <= '0;
`ifdef REG_ARB_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      ptr      <= ptr_n;
      wr_valid <= wr_en;
      if (wr_en) wr_src <= g;
`ifdef REG_ARB_LOCK_EN
      lock_cnt <= lock_cnt_n;
`endif
    end
  end

  dff_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en),
    .d     (wdata[int'(g)*WIDTH +: WIDTH]),
    .q     (q)
  );

endmodule
